// File: rtl/bus_cpu_core.sv
// bus_cpu_core: multi-cycle datapath with an NREGS x DATA_W register file,
// accumulator A, result register G and ALU sharing one internal bus.
// Instructions are accepted by a valid/ready handshake and run in 1 or 3 steps.
// Optional flags unit (flag_z, flag_c) is built when CPU_FLAGS_EN is defined.
module bus_cpu_core #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  localparam int RW    = $clog2(NREGS),
  localparam int IW    = 3 + 2 * RW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IW-1:0]     instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] bus,
  output logic [NREGS+1:0]  tri_en,
  output logic              done,
  input  logic [RW-1:0]     rd_sel,
  output logic [DATA_W-1:0] rd_data
`ifdef CPU_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_c
`endif
);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T3} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] g_q, g_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  logic [2:0]        op;
  logic [RW-1:0]     rx, ry;
  logic [NREGS-1:0]  rx_oh, ry_oh;
  logic              is_alu;

  // ALU result, modulo 2^DATA_W; SHL shifts in a zero and ignores b
  function automatic logic [DATA_W-1:0] alu_f(input logic [2:0] f_op,
                                              input logic [DATA_W-1:0] f_a,
                                              input logic [DATA_W-1:0] f_b);
    logic [DATA_W-1:0] r;
    case (f_op)
      OP_ADD:  r = f_a + f_b;
      OP_SUB:  r = f_a - f_b;
      OP_AND:  r = f_a & f_b;
      OP_XOR:  r = f_a ^ f_b;
      OP_SHL:  r = {f_a[DATA_W-2:0], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

`ifdef CPU_FLAGS_EN
  // Carry-out for ADD, borrow for SUB, bit shifted out for SHL, else 0
  function automatic logic carry_f(input logic [2:0] f_op,
                                   input logic [DATA_W-1:0] f_a,
                                   input logic [DATA_W-1:0] f_b);
    logic [DATA_W-1:0] s;
    logic c;
    s = f_a + f_b;
    case (f_op)
      OP_ADD:  c = (s < f_a);
      OP_SUB:  c = (f_a < f_b);
      OP_SHL:  c = f_a[DATA_W-1];
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  logic flag_z_q, flag_z_d;
  logic flag_c_q, flag_c_d;
  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
`endif

  assign op          = ir_q[IW-1 -: 3];
  assign rx          = ir_q[2*RW-1 -: RW];
  assign ry          = ir_q[RW-1:0];
  assign is_alu      = (op != OP_LOAD) && (op != OP_MOV) && (op != OP_NOP);
  assign instr_ready = (state_q == S_IDLE);
  assign rd_data     = regs_q[rd_sel];

  // One-hot decode of the register fields for the bus driver select
  always_comb begin
    rx_oh = '0;
    ry_oh = '0;
    for (int i = 0; i < NREGS; i++) begin
      rx_oh[i] = (rx == i[RW-1:0]);
      ry_oh[i] = (ry == i[RW-1:0]);
    end
  end

  // Bus driver select and done, decoded purely from registered state
  always_comb begin
    tri_en = '0;
    done   = 1'b0;
    case (state_q)
      S_T1: begin
        case (op)
          OP_LOAD: tri_en[NREGS]     = 1'b1;
          OP_MOV:  tri_en[NREGS-1:0] = ry_oh;
          OP_NOP:  tri_en            = '0;
          default: tri_en[NREGS-1:0] = rx_oh;
        endcase
        done = !is_alu;
      end
      S_T2: begin
        if (op != OP_SHL) tri_en[NREGS-1:0] = ry_oh;
      end
      S_T3: begin
        tri_en[NREGS+1] = 1'b1;
        done            = 1'b1;
      end
      default: begin
        tri_en = '0;
        done   = 1'b0;
      end
    endcase
  end

  // Bus value: OR of the selected drivers, zero when nothing drives it
  always_comb begin
    bus = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (tri_en[i]) bus = bus | regs_q[i];
    end
    if (tri_en[NREGS])   bus = bus | din;
    if (tri_en[NREGS+1]) bus = bus | g_q;
  end

  // Step sequencing and register-transfer updates
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    a_d     = a_q;
    g_d     = g_q;
    regs_d  = regs_q;
`ifdef CPU_FLAGS_EN
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_T1;
        end
      end
      S_T1: begin
        if (is_alu) begin
          a_d     = bus;
          state_d = S_T2;
        end else begin
          if (op != OP_NOP) regs_d[rx] = bus;
          state_d = S_IDLE;
        end
      end
      S_T2: begin
        g_d = alu_f(op, a_q, bus);
`ifdef CPU_FLAGS_EN
        flag_z_d = (g_d == '0);
        flag_c_d = carry_f(op, a_q, bus);
`endif
        state_d = S_T3;
      end
      S_T3: begin
        regs_d[rx] = bus;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; asynchronous reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
`ifdef CPU_FLAGS_EN
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      g_q     <= g_d;
      regs_q  <= regs_d;
`ifdef CPU_FLAGS_EN
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
`endif
    end
  end

endmodule

// File: tb/tb_bus_cpu_core.sv
// Testbench for bus_cpu_core (DATA_W=8, NREGS=4). Flag checks are compiled
// in when CPU_FLAGS_EN is defined.
module tb_bus_cpu_core;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] din;
  logic [7:0] bus;
  logic [5:0] tri_en;
  logic       done;
  logic [1:0] rd_sel;
  logic [7:0] rd_data;
`ifdef CPU_FLAGS_EN
  logic       flag_z;
  logic       flag_c;
`endif

  bus_cpu_core #(.DATA_W(8), .NREGS(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .din(din), .bus(bus), .tri_en(tri_en),
    .done(done), .rd_sel(rd_sel), .rd_data(rd_data)
`ifdef CPU_FLAGS_EN
    , .flag_z(flag_z), .flag_c(flag_c)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: register contents and flags as plain integers
  int model_r [4];
  int model_z = 0;
  int model_c = 0;

  typedef struct {
    logic [2:0] op;
    int         rx;
    int         ry;
    logic [7:0] dv;
    logic [7:0] exp_v;
    logic       chkf;
    logic       ez;
    logic       ec;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) model_r[i] = 0;
    model_z = 0;
    model_c = 0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_sel = i[1:0];
      #1;
      chk($sformatf("%s_R%0d", tag, i), {24'd0, rd_data}, model_r[i]);
    end
  endtask

  // Issue one instruction, follow its steps, and update the reference model
  task automatic run_instr(input logic [2:0] op, input int rx, input int ry, input logic [7:0] dv);
    int cyc;
    int steps;
    int a, b, s, res;
    int ec;
    logic seen;
    logic alu;
    logic [1:0] rx2, ry2;
    rx2 = rx[1:0];
    ry2 = ry[1:0];
    cyc = 0;
    while (!instr_ready && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ready_before_issue", {31'd0, instr_ready}, 1);
    instr       = {op, rx2, ry2};
    din         = dv;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;

    alu = (op >= 3'd2) && (op <= 3'd6);
    steps = alu ? 3 : 1;
    a = model_r[rx];
    b = model_r[ry];
    res = a;
    ec = 0;
    case (op)
      3'd0: res = dv;
      3'd1: res = b;
      3'd2: begin s = a + b; res = s % 256; ec = (s > 255) ? 1 : 0; end
      3'd3: begin res = (a - b + 256) % 256; ec = (a < b) ? 1 : 0; end
      3'd4: res = a & b;
      3'd5: res = a ^ b;
      3'd6: begin res = (a * 2) % 256; ec = (a >= 128) ? 1 : 0; end
      default: res = a;
    endcase

    seen = 1'b0;
    for (cyc = 1; cyc <= 6; cyc++) begin
      if (cyc > 1) begin @(posedge clk); #1; end
      if (cyc == 1) chk("ready_busy_t1", {31'd0, instr_ready}, 0);
      if (op == 3'd0 && cyc == 1) begin
        chk("load_bus", {24'd0, bus}, dv);
        chk("load_tri_en", {26'd0, tri_en}, 32'h10);
      end
      if (alu && cyc == 3) begin
        chk("alu_t3_bus", {24'd0, bus}, res);
        chk("alu_t3_tri_en", {26'd0, tri_en}, 32'h20);
      end
      if (done) begin seen = 1'b1; break; end
    end
    chk("done_seen", {31'd0, seen}, 1);
    if (seen) chk("done_step", cyc, steps);

    @(posedge clk); #1;
    chk("done_pulse_ends", {31'd0, done}, 0);
    chk("ready_after", {31'd0, instr_ready}, 1);
    if (op != 3'd7) model_r[rx] = res;
    if (alu) begin
      model_z = (res == 0) ? 1 : 0;
      model_c = ec;
    end
`ifdef CPU_FLAGS_EN
    chk("flag_z", {31'd0, flag_z}, model_z);
    chk("flag_c", {31'd0, flag_c}, model_c);
`endif
    check_regs("regs");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    tbl[0] = '{3'b000, 0, 0, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{3'b000, 1, 0, 8'h03, 8'h03, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{3'b010, 0, 1, 8'h00, 8'h08, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{3'b011, 1, 0, 8'h00, 8'hFB, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{3'b000, 2, 0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{3'b000, 3, 0, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{3'b010, 2, 3, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{3'b110, 3, 0, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0};

    rst = 1'b0;
    instr = '0;
    instr_valid = 1'b0;
    din = '0;
    rd_sel = '0;
    model_reset();

    // Reset held for two cycles
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ready", {31'd0, instr_ready}, 1);
    chk("rst_bus", {24'd0, bus}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_tri_en", {26'd0, tri_en}, 0);
    check_regs("rst");
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", {31'd0, instr_ready}, 1);
    chk("post_rst_done", {31'd0, done}, 0);

    // Directed table: LOAD/ADD/SUB/SHL sequence with known results
    for (int i = 0; i < 8; i++) begin
      run_instr(tbl[i].op, tbl[i].rx, tbl[i].ry, tbl[i].dv);
      rd_sel = tbl[i].rx[1:0];
      #1;
      chk($sformatf("tbl%0d_value", i), {24'd0, rd_data}, {24'd0, tbl[i].exp_v});
`ifdef CPU_FLAGS_EN
      if (tbl[i].chkf) begin
        chk($sformatf("tbl%0d_z", i), {31'd0, flag_z}, {31'd0, tbl[i].ez});
        chk($sformatf("tbl%0d_c", i), {31'd0, flag_c}, {31'd0, tbl[i].ec});
      end
`endif
    end

    // Valid held high across a busy ADD; a second instruction waits for IDLE
    run_instr(3'b000, 0, 0, 8'h11);
    run_instr(3'b000, 1, 0, 8'h22);
    @(posedge clk); #1;
    instr = 7'b010_00_01;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr = 7'b001_10_00;
    dn = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (done) dn++;
      if (c <= 3) chk($sformatf("hold_ready_t%0d", c), {31'd0, instr_ready}, 0);
      if (c == 4) chk("hold_ready_idle", {31'd0, instr_ready}, 1);
      if (c == 5) begin
        chk("hold_second_busy", {31'd0, instr_ready}, 0);
        chk("hold_second_done", {31'd0, done}, 1);
        instr_valid = 1'b0;
      end
    end
    chk("hold_done_count", dn, 2);
    model_r[0] = (model_r[0] + model_r[1]) % 256;
    model_r[2] = model_r[0];
    model_z = (model_r[0] == 0) ? 1 : 0;
    model_c = 0;
    check_regs("hold");

    // Reset asserted during T2 of ADD R0,R1
    instr = 7'b010_00_01;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_ready", {31'd0, instr_ready}, 1);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_bus", {24'd0, bus}, 0);
    chk("abort_tri_en", {26'd0, tri_en}, 0);
    model_reset();
    check_regs("abort");
    @(posedge clk); #1;
    chk("abort_hold_done", {31'd0, done}, 0);
    rst = 1'b1;
    dn = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("abort_no_done", dn, 0);
`ifdef CPU_FLAGS_EN
    chk("abort_flag_z", {31'd0, flag_z}, 0);
    chk("abort_flag_c", {31'd0, flag_c}, 0);
`endif
    run_instr(3'b000, 3, 0, 8'h5A);

    // Randomized instruction stream against the reference model
    for (int n = 0; n < 60; n++) begin
      logic [2:0] rop;
      logic [7:0] rdv;
      rop = 3'($urandom_range(0, 7));
      rdv = 8'($urandom);
      run_instr(rop, $urandom_range(0, 3), $urandom_range(0, 3), rdv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
